// File: rtl/window_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_pkg
// Brief    : State encoding and shared helpers for the window fetch engine.
// Revision : 1.0
// ============================================================================
package window_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_ARM_LO   = 4'd1,
        S_ARM_HI   = 4'd2,
        S_FETCH    = 4'd3,
        S_LATCH    = 4'd4,
        S_STROBE   = 4'd5,
        S_HOLD     = 4'd6,
        S_WAIT_DNE = 4'd7,
        S_WRITE    = 4'd8,
        S_NEXT     = 4'd9
    } state_t;

    function automatic int calc_win_n(input int ws);
        return ws * ws;
    endfunction

    function automatic int calc_radius(input int ws);
        return ws / 2;
    endfunction

    function automatic int calc_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_fetch_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_addr_gen
// Brief    : Maps (x,y,dx,dy) to an edge-replicated input RAM read address.
// Revision : 1.0
// ============================================================================
module window_addr_gen
    import window_pkg::*;
#(
    parameter int WINDOW_SIZE = 3,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int ADDR_W      = 16,
    parameter int IN_BASE     = 0,
    parameter int CW          = 4,
    parameter int DW          = 2
) (
    input  logic [CW-1:0]     i_x,
    input  logic [CW-1:0]     i_y,
    input  logic [DW-1:0]     i_dx,
    input  logic [DW-1:0]     i_dy,
    output logic [ADDR_W-1:0] o_raddr
);

    localparam int RADIUS = calc_radius(WINDOW_SIZE);

    logic signed [CW:0] w_row_s;
    logic signed [CW:0] w_col_s;
    int                 w_row;
    int                 w_col;

    // One extra sign bit keeps coordinate-minus-radius from wrapping before the clamp.
    always_comb begin
        w_row_s = $signed({1'b0, i_y}) + $signed((CW+1)'(i_dy)) - $signed((CW+1)'(RADIUS));
        w_col_s = $signed({1'b0, i_x}) + $signed((CW+1)'(i_dx)) - $signed((CW+1)'(RADIUS));
        w_row   = clamp_int(int'(w_row_s), 0, IMG_H - 1);
        w_col   = clamp_int(int'(w_col_s), 0, IMG_W - 1);
        o_raddr = ADDR_W'(IN_BASE + w_row * IMG_W + w_col);
    end

endmodule
`default_nettype wire

// File: rtl/window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : window_fetch
// Brief    : Scans an image, streams each pixel neighbourhood to the median
//            filter and writes the filter result to the output buffer.
// Revision : 1.0
// ============================================================================
module window_fetch
    import window_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int WINDOW_SIZE = 3,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int ADDR_W      = 16,
    parameter int IN_BASE     = 0,
    parameter int OUT_BASE    = 1024,
    parameter int DNE_TIMEOUT = 64
) (
    input  logic                  Win_CLK,
    input  logic                  Win_RST,
    input  logic                  Win_START,
    output logic                  Win_BUSY,
    output logic                  Win_DONE,
    output logic                  Win_ERR,
    output logic [ADDR_W-1:0]     Win_RADDR,
    input  logic [DATA_WIDTH-1:0] Win_RDATA,
    output logic                  Win_FEN,
    output logic                  Win_MEMRDY,
    output logic [DATA_WIDTH-1:0] Win_MEMDATA,
    input  logic                  Win_FDNE,
    input  logic [DATA_WIDTH-1:0] Win_FRES,
    output logic [ADDR_W-1:0]     Win_WADDR,
    output logic [DATA_WIDTH-1:0] Win_WDATA,
    output logic                  Win_WE
);

    localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW      = calc_bits(MAX_DIM + WINDOW_SIZE);
    localparam int DW      = calc_bits(WINDOW_SIZE);
    localparam int TW      = calc_bits(DNE_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         x_q, x_d, y_q, y_d;
    logic [DW-1:0]         dx_q, dx_d, dy_q, dy_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  fdne_prev_q, fdne_prev_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  fen_q, fen_d, memrdy_q, memrdy_d, we_q, we_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] memdata_q, memdata_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]     w_raddr;
    logic                  w_fdne_rise;

    // Address is generated from the next-cycle counters so RADDR is valid during FETCH.
    window_addr_gen #(
        .WINDOW_SIZE (WINDOW_SIZE),
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .ADDR_W      (ADDR_W),
        .IN_BASE     (IN_BASE),
        .CW          (CW),
        .DW          (DW)
    ) u_addr_gen (
        .i_x     (x_d),
        .i_y     (y_d),
        .i_dx    (dx_d),
        .i_dy    (dy_d),
        .o_raddr (w_raddr)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        tmo_d       = '0;
        fdne_prev_d = Win_FDNE;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        memdata_d   = memdata_q;
        wdata_d     = wdata_q;
        w_fdne_rise = Win_FDNE & ~fdne_prev_q;

        unique case (state_q)
            S_IDLE: begin
                if (Win_START) begin
                    state_d = S_ARM_LO;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    dx_d    = '0;
                    dy_d    = '0;
                end
            end
            S_ARM_LO: state_d = S_ARM_HI;
            S_ARM_HI: state_d = S_FETCH;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH: begin
                memdata_d = Win_RDATA;
                state_d   = S_STROBE;
            end
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (dx_q == DW'(WINDOW_SIZE - 1)) begin
                    dx_d = '0;
                    if (dy_q == DW'(WINDOW_SIZE - 1)) begin
                        dy_d    = '0;
                        state_d = S_WAIT_DNE;
                    end else begin
                        dy_d    = dy_q + DW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    dx_d    = dx_q + DW'(1);
                    state_d = S_FETCH;
                end
            end
            S_WAIT_DNE: begin
                if (w_fdne_rise) begin
                    wdata_d = Win_FRES;
                    state_d = S_WRITE;
                end else if (tmo_q == TW'(DNE_TIMEOUT - 1)) begin
                    wdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (x_q == CW'(IMG_W - 1)) begin
                    x_d = '0;
                    if (y_q == CW'(IMG_H - 1)) begin
                        y_d     = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        y_d     = y_q + CW'(1);
                        state_d = S_ARM_LO;
                    end
                end else begin
                    x_d     = x_q + CW'(1);
                    state_d = S_ARM_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that each registered output lines up with its state.
    always_comb begin
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        fen_d    = state_d inside {S_ARM_HI, S_FETCH, S_LATCH, S_STROBE,
                                   S_HOLD, S_WAIT_DNE, S_WRITE};
        memrdy_d = (state_d == S_STROBE);
        we_d     = (state_d == S_WRITE);
        if (state_d == S_FETCH) begin
            raddr_d = w_raddr;
        end
        if (state_d == S_WRITE) begin
            waddr_d = ADDR_W'(OUT_BASE + int'(y_q) * IMG_W + int'(x_q));
        end
    end

    always_ff @(posedge Win_CLK) begin
        if (Win_RST) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            tmo_q       <= '0;
            fdne_prev_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fen_q       <= 1'b0;
            memrdy_q    <= 1'b0;
            we_q        <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            memdata_q   <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            tmo_q       <= tmo_d;
            fdne_prev_q <= fdne_prev_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fen_q       <= fen_d;
            memrdy_q    <= memrdy_d;
            we_q        <= we_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            memdata_q   <= memdata_d;
            wdata_q     <= wdata_d;
        end
    end

    assign Win_BUSY    = busy_q;
    assign Win_DONE    = done_q;
    assign Win_ERR     = err_q;
    assign Win_RADDR   = raddr_q;
    assign Win_FEN     = fen_q;
    assign Win_MEMRDY  = memrdy_q;
    assign Win_MEMDATA = memdata_q;
    assign Win_WADDR   = waddr_q;
    assign Win_WDATA   = wdata_q;
    assign Win_WE      = we_q;

endmodule
`default_nettype wire

// File: tb/tb_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_fetch
// Brief    : Self-checking bench: RAM and median-filter models, vector table,
//            randomized image scans against a behavioural reference.
// Revision : 1.0
// ============================================================================
module tb_window_fetch;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int WS    = 3;
    localparam int N     = W * H;
    localparam int DWID  = 24;
    localparam int AW    = 16;
    localparam int OB    = 1024;
    localparam int TO    = 64;
    localparam int LIMIT = 5000;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic            busy, done, err, fen, memrdy, we;
    logic            fdne = 1'b0;
    logic [AW-1:0]   raddr, waddr;
    logic [DWID-1:0] rdata = '0, memdata, wdata;
    logic [DWID-1:0] fres = '0;

    window_fetch #(
        .DATA_WIDTH(DWID), .WINDOW_SIZE(WS), .IMG_W(W), .IMG_H(H),
        .ADDR_W(AW), .IN_BASE(0), .OUT_BASE(OB), .DNE_TIMEOUT(TO)
    ) dut (
        .Win_CLK(clk), .Win_RST(rst), .Win_START(start), .Win_BUSY(busy),
        .Win_DONE(done), .Win_ERR(err), .Win_RADDR(raddr), .Win_RDATA(rdata),
        .Win_FEN(fen), .Win_MEMRDY(memrdy), .Win_MEMDATA(memdata),
        .Win_FDNE(fdne), .Win_FRES(fres), .Win_WADDR(waddr), .Win_WDATA(wdata),
        .Win_WE(we)
    );

    always #5 clk = ~clk;

    logic [DWID-1:0] mem [N];
    always @(posedge clk) rdata <= (raddr < AW'(N)) ? mem[raddr[3:0]] : 24'hBADBAD;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int median9(input int v [9]);
        int a [9];
        int t;
        a = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        return a[4];
    endfunction

    function automatic int clampv(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Reference: tap k of window (x,y) with edge replication, row-major order
    function automatic int ref_tap(input int x, input int y, input int k);
        int r, c;
        r = clampv(y + k / WS - WS / 2, H - 1);
        c = clampv(x + k % WS - WS / 2, W - 1);
        return int'(mem[r * W + c]);
    endfunction

    function automatic int ref_result(input int x, input int y);
        int v [9];
        for (int k = 0; k < 9; k++) v[k] = ref_tap(x, y, k);
        return median9(v);
    endfunction

    // Filter model: collects taps on MEMRDY falling edge, answers after a random delay
    int skip_win = -1, zero_win = -1;
    int f_win = 0, ntaps = 0, wait_cnt = -1;
    int ftaps [9];
    bit f_fen_p = 0, f_rdy_p = 0;

    always @(negedge clk) begin
        if (rst) begin
            fdne = 1'b0; f_fen_p = 0; f_rdy_p = 0; ntaps = 0; wait_cnt = -1;
        end else begin
            if (fen && !f_fen_p) begin
                ntaps = 0; f_win++; fdne = 1'b0; wait_cnt = -1;
            end
            if (!fen) fdne = 1'b0;
            if (f_rdy_p && !memrdy && ntaps < 9) begin
                ftaps[ntaps] = int'(memdata);
                ntaps++;
                if (ntaps == 9)
                    wait_cnt = (f_win - 1 == zero_win) ? 0 : int'($urandom_range(8, 1));
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else if (wait_cnt == 0) begin
                wait_cnt = -1;
                if (f_win - 1 != skip_win) begin
                    fres = DWID'(median9(ftaps));
                    fdne = 1'b1;
                end
            end
            f_fen_p = fen; f_rdy_p = memrdy;
        end
    end

    // Monitor: logs writes and taps, counts timing violations
    int m_win = 0, m_cyc = 0, fen_rise_cyc = 0, viol = 0, done_cnt = 0;
    bit m_fen_p = 0, m_rdy_p = 0, first_seen = 0;
    logic [DWID-1:0] m_md_p = '0;
    int tap_log [N][9];
    int tap_cnt [N];
    int wr_addr [$];
    int wr_data [$];

    always @(negedge clk) begin
        m_cyc++;
        if (rst) begin
            m_fen_p = 0; m_rdy_p = 0;
        end else begin
            if (we) begin
                wr_addr.push_back(int'(waddr));
                wr_data.push_back(int'(wdata));
            end
            if (done) done_cnt++;
            if (fen && !m_fen_p) begin
                m_win++; fen_rise_cyc = m_cyc; first_seen = 0;
            end
            if (memrdy) begin
                if (m_rdy_p || !fen) viol++;
                if (!first_seen) begin
                    if (m_cyc - fen_rise_cyc < 2) viol++;
                    first_seen = 1;
                end
                if (m_win >= 1 && m_win <= N && tap_cnt[m_win-1] < 9) begin
                    tap_log[m_win-1][tap_cnt[m_win-1]] = int'(memdata);
                    tap_cnt[m_win-1]++;
                end
            end
            if (m_rdy_p && memdata !== m_md_p) viol++;
            m_fen_p = fen; m_rdy_p = memrdy; m_md_p = memdata;
        end
    end

    task automatic clear_logs();
        m_win = 0; f_win = 0; viol = 0; done_cnt = 0;
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < N; i++) tap_cnt[i] = 0;
    endtask

    task automatic run_image(input string tag, input int skip, input int zero, input bit repulse);
        int n;
        int exp_d;
        int bad;
        clear_logs();
        skip_win = skip; zero_win = zero;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        check({tag, " busy"}, busy, 1);
        @(negedge clk); start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
            start = repulse && busy && (n % 37 == 5);
        end
        start = 1'b0;
        check({tag, " done_seen"}, done_cnt > 0, 1);
        repeat (4) @(negedge clk);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " writes"}, wr_addr.size(), N);
        check({tag, " err"}, err, (skip >= 0 || zero >= 0) ? 1 : 0);
        check({tag, " timing"}, viol, 0);
        for (int i = 0; i < N && i < wr_addr.size(); i++) begin
            exp_d = (i == skip || i == zero) ? 0 : ref_result(i % W, i / W);
            check($sformatf("%s wr%0d addr", tag, i), wr_addr[i], OB + i);
            check($sformatf("%s wr%0d data", tag, i), wr_data[i], exp_d);
        end
        for (int i = 0; i < N; i++) begin
            bad = (tap_cnt[i] == 9) ? 0 : 1;
            for (int k = 0; k < tap_cnt[i]; k++)
                if (tap_log[i][k] != ref_tap(i % W, i / W, k)) bad++;
            check($sformatf("%s win%0d taps", tag, i), bad, 0);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int taps [9];
        int res;
        int addr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n;
        vecs[0].x = 0; vecs[0].y = 0; vecs[0].taps = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
        vecs[0].res = 1;  vecs[0].addr = 1024;
        vecs[1].x = 1; vecs[1].y = 1; vecs[1].taps = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        vecs[1].res = 5;  vecs[1].addr = 1029;
        vecs[2].x = 3; vecs[2].y = 0; vecs[2].taps = '{2, 3, 3, 2, 3, 3, 6, 7, 7};
        vecs[2].res = 3;  vecs[2].addr = 1027;
        vecs[3].x = 3; vecs[3].y = 3; vecs[3].taps = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
        vecs[3].res = 14; vecs[3].addr = 1039;

        for (int i = 0; i < N; i++) mem[i] = DWID'(i);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ctrl", {busy, done, err, fen, memrdy, we}, 0);
        check("reset raddr", raddr, 0);
        check("reset waddr", waddr, 0);
        check("reset data", {memdata, wdata}, 0);
        rst = 1'b0;

        run_image("base", -1, -1, 0);
        for (int v = 0; v < 4; v++) begin
            int idx;
            int bad;
            idx = vecs[v].y * W + vecs[v].x;
            bad = 0;
            for (int k = 0; k < 9; k++)
                if (tap_log[idx][k] != vecs[v].taps[k]) bad++;
            check($sformatf("vec%0d taps", v), bad, 0);
            check($sformatf("vec%0d waddr", v), (idx < wr_addr.size()) ? wr_addr[idx] : -1, vecs[v].addr);
            check($sformatf("vec%0d wdata", v), (idx < wr_data.size()) ? wr_data[idx] : -1, vecs[v].res);
        end

        run_image("repulse", -1, -1, 1);
        run_image("timeout", 3, -1, 0);
        run_image("stale_fdne", -1, 6, 0);

        // Reset while strobing the third window
        clear_logs();
        skip_win = -1; zero_win = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(m_win == 3 && memrdy) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("rstmid reached", (m_win == 3 && memrdy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid ctrl", {busy, done, err, fen, memrdy, we}, 0);
        check("rstmid raddr", raddr, 0);
        check("rstmid waddr", waddr, 0);
        check("rstmid data", {memdata, wdata}, 0);
        repeat (2) @(negedge clk);
        check("rstmid writes", wr_addr.size(), 2);
        rst = 1'b0;
        run_image("post_rst", -1, -1, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) mem[i] = DWID'($urandom);
            run_image($sformatf("rand%0d", r), (r == 2) ? int'($urandom_range(N - 1, 0)) : -1, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
